// File: rtl/segment_transition_ctl_pkg.sv
// Shared types and defaults for the segment transition controller.
// GPIO-triggered transitions exist only when SEGMENT_TRANSITION_GPIO_EN is defined.
package segment_transition_ctl_pkg;

  localparam int unsigned NumSegmentDefault = 4;
  localparam int unsigned IdxWidthDefault   = 13;
  localparam int unsigned RepWidthDefault   = 16;
  localparam int unsigned NumGpioDefault    = 4;

  localparam logic [RepWidthDefault-1:0] RepInfinite = '1;

  typedef enum logic [7:0] {
    TransitionModeSyncIdx = 8'h00,
    TransitionModeSysTime = 8'h01,
    TransitionModeGpio    = 8'h02,
    TransitionModeExt     = 8'hF0
  } transition_mode_t;

  typedef enum logic [1:0] {
    StRun      = 2'd0,
    StWaitSync = 2'd1,
    StWaitTime = 2'd2,
    StWaitGpio = 2'd3
  } seg_trans_state_t;

  function automatic logic mode_supported(logic [7:0] mode);
    logic ok;
    ok = (mode == TransitionModeSyncIdx) || (mode == TransitionModeSysTime) ||
         (mode == TransitionModeExt);
`ifdef SEGMENT_TRANSITION_GPIO_EN
    ok = ok || (mode == TransitionModeGpio);
`endif
    return ok;
  endfunction

endpackage

// File: rtl/segment_transition_ctl_if.sv
// Request/playback bundle between the register bank (master) and the sequencer (slave).
// gpio_in is only consumed when SEGMENT_TRANSITION_GPIO_EN is defined.
interface segment_transition_ctl_if
  import segment_transition_ctl_pkg::*;
#(
  parameter int unsigned NumSegment = NumSegmentDefault,
  parameter int unsigned IdxWidth   = IdxWidthDefault,
  parameter int unsigned RepWidth   = RepWidthDefault,
  parameter int unsigned NumGpio    = NumGpioDefault
);
  localparam int unsigned SegW = $clog2(NumSegment);

  logic                                 update;
  logic [SegW-1:0]                      req_segment;
  logic [7:0]                           req_mode;
  logic [31:0]                          req_value;
  logic [NumSegment-1:0][IdxWidth-1:0]  cycle;
  logic [NumSegment-1:0][RepWidth-1:0]  rep;
  logic                                 tick;
  logic [31:0]                          sys_time;
  logic [NumGpio-1:0]                   gpio_in;

  logic [SegW-1:0]                      segment;
  logic [IdxWidth-1:0]                  idx;
  logic                                 stop;
  logic                                 pending;
  logic                                 err;

  modport master (
    output update, req_segment, req_mode, req_value, cycle, rep, tick, sys_time, gpio_in,
    input  segment, idx, stop, pending, err
  );

  modport slave (
    input  update, req_segment, req_mode, req_value, cycle, rep, tick, sys_time, gpio_in,
    output segment, idx, stop, pending, err
  );

endinterface

// File: rtl/segment_transition_ctl_seg_loop_counter.sv
// Playback index and loop counter for the active segment; clear_i restarts it.
// rep_done_o flags the tick that would start loop rep_i+1 (finite repeat only).
module segment_transition_ctl_seg_loop_counter #(
  parameter int unsigned IdxWidth = 13,
  parameter int unsigned RepWidth = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clear_i,
  input  logic                tick_i,
  input  logic [IdxWidth-1:0] cycle_i,
  input  logic [RepWidth-1:0] rep_i,
  output logic [IdxWidth-1:0] idx_o,
  output logic                stop_o,
  output logic                wrap_next_o,
  output logic                rep_done_o
);

  logic [IdxWidth-1:0] idx_q, idx_d;
  logic [RepWidth-1:0] loop_q, loop_d;
  logic                stop_q, stop_d;
  logic                advance;

  // >= rather than == so a CYCLE shrunk below the current index wraps on the next tick
  assign wrap_next_o = idx_q >= cycle_i;
  assign advance     = tick_i & ~stop_q;
  assign rep_done_o  = advance & wrap_next_o & ~(&rep_i) & (loop_q >= rep_i);

  always_comb begin
    idx_d  = idx_q;
    loop_d = loop_q;
    stop_d = stop_q;
    if (clear_i) begin
      idx_d  = '0;
      loop_d = '0;
      stop_d = 1'b0;
    end else if (rep_done_o) begin
      stop_d = 1'b1;
    end else if (advance) begin
      if (wrap_next_o) begin
        idx_d  = '0;
        loop_d = loop_q + RepWidth'(1);
      end else begin
        idx_d = idx_q + IdxWidth'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx_q  <= '0;
      loop_q <= '0;
      stop_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      loop_q <= loop_d;
      stop_q <= stop_d;
    end
  end

  assign idx_o  = idx_q;
  assign stop_o = stop_q;

endmodule

// File: rtl/segment_transition_ctl.sv
// Segment sequencer: holds a segment-change request until its trigger, then restarts playback.
// Define SEGMENT_TRANSITION_GPIO_EN to enable GPIO rising-edge triggered transitions.
module segment_transition_ctl
  import segment_transition_ctl_pkg::*;
#(
  parameter int unsigned NumSegment = NumSegmentDefault,
  parameter int unsigned IdxWidth   = IdxWidthDefault,
  parameter int unsigned RepWidth   = RepWidthDefault,
  parameter int unsigned NumGpio    = NumGpioDefault
) (
  input logic                    CLK,
  input logic                    RST,
  segment_transition_ctl_if.slave bus
);

  localparam int unsigned     SegW    = $clog2(NumSegment);
  localparam logic [SegW-1:0] LastSeg = SegW'(NumSegment - 1);

  seg_trans_state_t state_q, state_d;
  logic [SegW-1:0]  seg_q, seg_d;
  logic [SegW-1:0]  target_q, target_d;
  logic [31:0]      value_q, value_d;
  logic             ext_armed_q, ext_armed_d;
  logic             pending_q, pending_d;
  logic             err_q, err_d;

  logic             req_ok;
  logic             switch_now;
  logic [SegW-1:0]  switch_seg;
  logic             wrap_next, stop, rep_done;
  logic [31:0]      time_diff;
  logic             time_reached;
  logic             gpio_edge;

  assign req_ok       = (32'(bus.req_segment) < NumSegment) && mode_supported(bus.req_mode);
  // Sign of the wrapped difference keeps the compare valid across SYS_TIME rollover
  assign time_diff    = bus.sys_time - value_q;
  assign time_reached = ~time_diff[31];

`ifdef SEGMENT_TRANSITION_GPIO_EN
  localparam int unsigned GpioSelW = (NumGpio > 1) ? $clog2(NumGpio) : 1;
  logic [NumGpio-1:0]  gpio_hist_q;
  logic [GpioSelW-1:0] gpio_sel;

  assign gpio_sel  = value_q[GpioSelW-1:0];
  assign gpio_edge = bus.gpio_in[gpio_sel] & ~gpio_hist_q[gpio_sel];

  always_ff @(posedge CLK) begin
    if (RST) begin
      gpio_hist_q <= '0;
    end else begin
      gpio_hist_q <= bus.gpio_in;
    end
  end
`else
  logic unused_gpio;
  assign unused_gpio = ^bus.gpio_in;
  assign gpio_edge   = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    seg_d       = seg_q;
    target_d    = target_q;
    value_d     = value_q;
    ext_armed_d = ext_armed_q;
    pending_d   = pending_q;
    err_d       = err_q;
    switch_now  = 1'b0;
    switch_seg  = target_q;

    if (bus.update && req_ok) begin
      // An accepted request discards whatever trigger the older request had this cycle
      err_d       = 1'b0;
      target_d    = bus.req_segment;
      value_d     = bus.req_value;
      ext_armed_d = 1'b0;
      case (bus.req_mode)
        TransitionModeSyncIdx: begin
          state_d   = StWaitSync;
          pending_d = 1'b1;
        end
        TransitionModeSysTime: begin
          state_d   = StWaitTime;
          pending_d = 1'b1;
        end
        TransitionModeGpio: begin
          state_d   = StWaitGpio;
          pending_d = 1'b1;
        end
        default: begin
          switch_now  = 1'b1;
          switch_seg  = bus.req_segment;
          ext_armed_d = 1'b1;
        end
      endcase
    end else begin
      if (bus.update) begin
        err_d = 1'b1;
      end
      unique case (state_q)
        StRun: begin
          switch_now = rep_done & ext_armed_q;
          switch_seg = (seg_q == LastSeg) ? '0 : seg_q + SegW'(1);
        end
        StWaitSync: switch_now = bus.tick & (wrap_next | stop);
        StWaitTime: switch_now = time_reached;
        StWaitGpio: switch_now = gpio_edge;
        default:    switch_now = 1'b0;
      endcase
    end

    if (switch_now) begin
      seg_d     = switch_seg;
      state_d   = StRun;
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= StRun;
      seg_q       <= '0;
      target_q    <= '0;
      value_q     <= '0;
      ext_armed_q <= 1'b0;
      pending_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      seg_q       <= seg_d;
      target_q    <= target_d;
      value_q     <= value_d;
      ext_armed_q <= ext_armed_d;
      pending_q   <= pending_d;
      err_q       <= err_d;
    end
  end

  segment_transition_ctl_seg_loop_counter #(
    .IdxWidth(IdxWidth),
    .RepWidth(RepWidth)
  ) u_loop (
    .clk_i      (CLK),
    .rst_i      (RST),
    .clear_i    (switch_now),
    .tick_i     (bus.tick),
    .cycle_i    (bus.cycle[seg_q]),
    .rep_i      (bus.rep[seg_q]),
    .idx_o      (bus.idx),
    .stop_o     (stop),
    .wrap_next_o(wrap_next),
    .rep_done_o (rep_done)
  );

  assign bus.segment = seg_q;
  assign bus.stop    = stop;
  assign bus.pending = pending_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_segment_transition_ctl.sv
// Self-checking bench: directed scenarios with literal expectations plus randomized traffic,
// all outputs compared every cycle against a behavioural model of the sequencing rules.
module tb_segment_transition_ctl;
  import segment_transition_ctl_pkg::*;

  localparam int unsigned NS  = 5;
  localparam int unsigned IW  = 13;
  localparam int unsigned RW  = 16;
  localparam int unsigned NG  = 4;
  localparam int unsigned SW  = $clog2(NS);

  localparam logic [7:0] MSync = 8'(TransitionModeSyncIdx);
  localparam logic [7:0] MTime = 8'(TransitionModeSysTime);
  localparam logic [7:0] MGpio = 8'(TransitionModeGpio);
  localparam logic [7:0] MExt  = 8'(TransitionModeExt);

  logic clk;
  logic rst;
  bit   chk_en;
  int   n_checks;
  int   n_fail;

  segment_transition_ctl_if #(.NumSegment(NS), .IdxWidth(IW), .RepWidth(RW), .NumGpio(NG)) bus ();

  segment_transition_ctl #(
    .NumSegment(NS),
    .IdxWidth  (IW),
    .RepWidth  (RW),
    .NumGpio   (NG)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(string name, longint act, longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endfunction

  function automatic bit mode_known(logic [7:0] m);
`ifdef SEGMENT_TRANSITION_GPIO_EN
    return (m == MSync) || (m == MTime) || (m == MGpio) || (m == MExt);
`else
    return (m == MSync) || (m == MTime) || (m == MExt);
`endif
  endfunction

  // ---------------- behavioural model ----------------
  typedef enum int {WNone, WSync, WTime, WGpio} wait_e;
  int unsigned     m_seg, m_idx, m_loops, m_target;
  bit              m_stop, m_err, m_ext;
  wait_e           m_wait;
  logic [31:0]     m_value;
  logic [NG-1:0]   m_gprev;

  always @(posedge clk) begin : model
    int unsigned last, rep_n, nxt;
    bit adv, wraps, finished, accept, sw;
    if (rst) begin
      m_seg = 0; m_idx = 0; m_loops = 0; m_target = 0; m_stop = 0; m_err = 0; m_ext = 0;
      m_wait = WNone; m_value = '0; m_gprev = '0;
    end else begin
      last     = bus.cycle[m_seg];
      rep_n    = bus.rep[m_seg];
      adv      = bus.tick && !m_stop;
      wraps    = m_idx >= last;
      finished = adv && wraps && (rep_n != RepInfinite) && (m_loops >= rep_n);
      accept   = bus.update && (bus.req_segment < NS) && mode_known(bus.req_mode);
      sw       = 0;
      nxt      = 0;
      if (bus.update && !accept) m_err = 1;
      if (accept) begin
        m_err = 0; m_ext = 0; m_target = bus.req_segment; m_value = bus.req_value;
        if (bus.req_mode == MSync) m_wait = WSync;
        else if (bus.req_mode == MTime) m_wait = WTime;
        else if (bus.req_mode == MGpio) m_wait = WGpio;
        else begin
          sw = 1; nxt = bus.req_segment; m_ext = 1;
        end
      end else begin
        case (m_wait)
          WSync: if (bus.tick && (wraps || m_stop)) begin sw = 1; nxt = m_target; end
          WTime: if ($signed(bus.sys_time - m_value) >= 0) begin sw = 1; nxt = m_target; end
          WGpio: if (bus.gpio_in[m_value[1:0]] && !m_gprev[m_value[1:0]]) begin
            sw = 1; nxt = m_target;
          end
          default: if (finished && m_ext) begin sw = 1; nxt = (m_seg + 1) % NS; end
        endcase
      end
      if (sw) begin
        m_seg = nxt; m_idx = 0; m_loops = 0; m_stop = 0; m_wait = WNone;
      end else if (finished) begin
        m_stop = 1;
      end else if (adv) begin
        if (wraps) begin m_idx = 0; m_loops++; end
        else m_idx++;
      end
      m_gprev = bus.gpio_in;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("segment", bus.segment, m_seg);
      check("idx", bus.idx, m_idx);
      check("stop", bus.stop, m_stop);
      check("pending", bus.pending, m_wait != WNone);
      check("err", bus.err, m_err);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  task automatic send(int seg, logic [7:0] mode, logic [31:0] val);
    bus.update      = 1'b1;
    bus.req_segment = SW'(seg);
    bus.req_mode    = mode;
    bus.req_value   = val;
    step();
    bus.update = 1'b0;
  endtask

  task automatic set_all(int cyc, int rep);
    for (int i = 0; i < NS; i++) begin
      bus.cycle[i] = IW'(cyc);
      bus.rep[i]   = RW'(rep);
    end
  endtask

  initial begin
    int t1_idx[9];
    int t1_stop[9];
    int t5_seg[4];
    t1_idx  = '{1, 2, 3, 0, 1, 2, 3, 3, 3};
    t1_stop = '{0, 0, 0, 0, 0, 0, 0, 1, 1};
    t5_seg  = '{2, 3, 4, 0};
    n_checks = 0; n_fail = 0; chk_en = 0;
    rst = 1'b1;
    bus.update = 0; bus.req_segment = '0; bus.req_mode = '0; bus.req_value = '0;
    bus.tick = 0; bus.sys_time = '0; bus.gpio_in = '0;
    set_all(3, RepInfinite);

    // Reset state and finite repeat
    bus.rep[0] = RW'(1);
    do_reset();
    chk_en = 1;
    check("rst_segment", bus.segment, 0);
    check("rst_idx", bus.idx, 0);
    check("rst_stop", bus.stop, 0);
    check("rst_pending", bus.pending, 0);
    check("rst_err", bus.err, 0);
    for (int k = 0; k < 9; k++) begin
      bus.tick = 1; step(); bus.tick = 0;
      check("rep_idx", bus.idx, t1_idx[k]);
      check("rep_stop", bus.stop, t1_stop[k]);
      check("model_rep_idx", m_idx, t1_idx[k]);
      step(3);
    end

    // SYNC_IDX request mid-loop
    set_all(3, RepInfinite);
    do_reset();
    bus.tick = 1; step(2); bus.tick = 0;
    send(2, MSync, 0);
    check("sync_pending", bus.pending, 1);
    check("sync_seg_hold", bus.segment, 0);
    bus.tick = 1; step();
    check("sync_idx3", bus.idx, 3);
    check("sync_seg_still0", bus.segment, 0);
    step(); bus.tick = 0;
    check("sync_seg2", bus.segment, 2);
    check("sync_idx0", bus.idx, 0);
    check("sync_pending_clr", bus.pending, 0);

    // SYS_TIME across rollover
    do_reset();
    bus.sys_time = 32'hFFFF_FFF0;
    send(1, MTime, 32'h0000_0010);
    for (int t = 0; t < 36; t++) begin
      bus.sys_time = bus.sys_time + 32'd1;
      step();
      if (bus.sys_time == 32'h0000_000F) check("time_before", bus.segment, 0);
      if (bus.sys_time == 32'h0000_0010) begin
        check("time_switch", bus.segment, 1);
        check("time_pending_clr", bus.pending, 0);
      end
    end

    // GPIO trigger
    do_reset();
`ifdef SEGMENT_TRANSITION_GPIO_EN
    bus.gpio_in = 4'b0100;
    step(3);
    send(3, MGpio, 2);
    step(3);
    check("gpio_held_no_switch", bus.segment, 0);
    check("gpio_pending", bus.pending, 1);
    bus.gpio_in = 4'b0010; step();
    bus.gpio_in = 4'b0000; step();
    check("gpio_other_pin", bus.segment, 0);
    bus.gpio_in = 4'b0100; step();
    check("gpio_switch", bus.segment, 3);
    check("gpio_pending_clr", bus.pending, 0);
`else
    send(3, MGpio, 2);
    check("gpio_rejected_err", bus.err, 1);
    check("gpio_rejected_pending", bus.pending, 0);
`endif
    bus.gpio_in = '0;

    // EXT auto-advance, one loop per segment
    set_all(1, 0);
    do_reset();
    send(1, MExt, 0);
    check("ext_first", bus.segment, 1);
    check("ext_pending", bus.pending, 0);
    for (int s = 0; s < 4; s++) begin
      bus.tick = 1; step(2); bus.tick = 0;
      check("ext_seq", bus.segment, t5_seg[s]);
      check("ext_idx", bus.idx, 0);
    end

    // Rejected requests, error clearing, reset mid-wait
    set_all(3, RepInfinite);
    do_reset();
    send(1, MSync, 0);
    send(5, MSync, 0);
    check("bad_seg_err", bus.err, 1);
    check("bad_seg_pending", bus.pending, 1);
    send(2, 8'h77, 0);
    check("bad_mode_err", bus.err, 1);
    send(2, MTime, bus.sys_time + 32'd1000);
    check("err_cleared", bus.err, 0);
    check("err_pending", bus.pending, 1);
    rst = 1'b1; step(); rst = 1'b0;
    check("rst_drops_pending", bus.pending, 0);

    // Randomized traffic
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      bus.tick = ($urandom_range(0, 99) < 35);
      bus.sys_time = bus.sys_time + 32'($urandom_range(1, 2));
      if ($urandom_range(0, 9) == 0) bus.gpio_in = NG'($urandom);
      bus.update = ($urandom_range(0, 99) < 4);
      if (bus.update) begin
        int r;
        r = $urandom_range(0, 9);
        bus.req_segment = SW'($urandom_range(0, 7));
        bus.req_value   = $urandom;
        if (r < 3) bus.req_mode = MSync;
        else if (r < 5) begin
          bus.req_mode  = MTime;
          bus.req_value = bus.sys_time + 32'($urandom_range(0, 60)) - 32'd20;
        end else if (r < 7) begin
          bus.req_mode  = MGpio;
          bus.req_value = 32'($urandom_range(0, 3));
        end else if (r < 9) bus.req_mode = MExt;
        else bus.req_mode = 8'($urandom);
      end
      if ($urandom_range(0, 149) == 0) begin
        int i;
        i = $urandom_range(0, NS - 1);
        bus.cycle[i] = IW'($urandom_range(0, 6));
        bus.rep[i]   = ($urandom_range(0, 3) == 3) ? RepInfinite : RW'($urandom_range(0, 2));
      end
      rst = ($urandom_range(0, 999) == 0);
      step();
    end
    rst = 1'b0;
    bus.update = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
